// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Event bundle, prefix byte values, frame FSM states, parity helper.
package ps2_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_event_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    // Odd parity over 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] b,
                                           input logic       p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO of ps2_event_t with occupancy count.
// Ports: clk_i, reset_i (sync, high), push_i/data_i, pop_i, data_o (head),
//        count_o, full_o, empty_o.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  ps2_event_t               data_i,
    input  logic                     pop_i,
    output ps2_event_t               data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ps2_event_t    mem_q [DEPTH];
    ps2_event_t    last_q, last_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // While empty the last popped head stays visible.
    assign data_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q];
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: pin sync/filter, frame FSM, E0/F0 decode, event FIFO.
// Ports: clk, reset (sync, high), ps2_clk/ps2_data (raw pins), ev_ready,
//        status_clr, ev_valid/ev_data/fifo_count, overflow, err_count.
// Option: PS2_TYPEMATIC_SUPPRESS_EN drops repeated makes of held keys.
module ps2_kbd_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          ev_ready,
    input  logic                          status_clr,
    output logic                          ev_valid,
    output logic [9:0]                    ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic ps2c_s1_q, ps2c_s2_q;
    logic ps2d_s1_q, ps2d_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1_q <= 1'b1;
            ps2c_s2_q <= 1'b1;
            ps2d_s1_q <= 1'b1;
            ps2d_s2_q <= 1'b1;
        end else begin
            ps2c_s1_q <= ps2_clk;
            ps2c_s2_q <= ps2c_s1_q;
            ps2d_s1_q <= ps2_data;
            ps2d_s2_q <= ps2d_s1_q;
        end
    end

    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;
    logic          sample;

    // Run of samples disagreeing with the filtered level; any agreeing
    // sample restarts the run, so short glitches never flip the level.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (ps2c_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
            else filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign strobe = filt_prev_q & ~filt_q;
    assign sample = ps2d_s2_q;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_ok_q, byte_ok_d;
    logic          frame_err;
    logic          timeout;

    assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        byte_ok_d = 1'b0;
        frame_err = 1'b0;
        tmo_d     = (strobe || state_q == IDLE) ? '0 : tmo_q + 1'b1;
        if (timeout) begin
            state_d   = IDLE;
            frame_err = 1'b1;
            tmo_d     = '0;
        end else if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (!sample) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {sample, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = sample;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (sample && odd_parity_ok(shift_q, par_q))
                        byte_ok_d = 1'b1;
                    else
                        frame_err = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            byte_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            byte_ok_q <= byte_ok_d;
        end
    end

    // shift_q stays stable until the next start bit, so the decoder can
    // read it in the cycle after the stop strobe.
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       key_ev;
    logic       push;
    ps2_event_t ev_in;

    assign ev_in = '{brk: brk_q, ext: ext_q, code: shift_q};

    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        key_ev = 1'b0;
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok_q) begin
            unique case (1'b1)
                (shift_q == PS2_PREFIX_EXT): ext_d = 1'b1;
                (shift_q == PS2_PREFIX_BRK): brk_d = 1'b1;
                default: begin
                    key_ev = 1'b1;
                    ext_d  = 1'b0;
                    brk_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    logic [1:0] held_q [256];
    logic       held;

    assign held = held_q[shift_q][ext_q];
    assign push = key_ev & ~(~brk_q & held);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) held_q[i] <= '0;
        end else if (key_ev) begin
            held_q[shift_q][ext_q] <= ~brk_q;
        end
    end
`else
    assign push = key_ev;
`endif

    ps2_event_t fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       drop;

    assign pop  = ev_valid & ev_ready;
    assign drop = push & fifo_full & ~pop;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .data_i  (ev_in),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_data  = fifo_head;

    logic                 ovf_q, ovf_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    // A new error or drop in the same cycle as status_clr wins.
    always_comb begin
        ovf_d = ovf_q;
        err_d = err_q;
        if (drop) ovf_d = 1'b1;
        else if (status_clr) ovf_d = 1'b0;
        if (frame_err) begin
            if (status_clr) err_d = ERR_CNT_W'(1);
            else if (err_q != '1) err_d = err_q + 1'b1;
        end else if (status_clr) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            err_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign overflow  = ovf_q;
    assign err_count = err_q;

endmodule
